// File: rtl/ter_pi_addr_seq.sv
// Turbo permutation ROM address sequencer: walks a link's ROM segment and streams
// (i, pi(i)) pairs over valid/ready, absorbing the 1-cycle ROM read latency.
module ter_pi_addr_seq #(
   parameter int A_WIDTH  = 16,
   parameter int D_WIDTH  = 13,
   parameter int ID_WIDTH = 6
) (
   input  logic                clk,
   input  logic                n_rst,
   input  logic                start,
   input  logic [ID_WIDTH-1:0] link_id,
   output logic                busy,
   output logic                err,
   output logic [A_WIDTH-1:0]  rom_addr,
   input  logic [D_WIDTH-1:0]  rom_data,
   output logic [D_WIDTH-1:0]  pi_len,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [D_WIDTH-1:0]  out_idx,
   output logic [D_WIDTH-1:0]  out_pi,
   output logic                done
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   // Segment start addresses; an id's length is the next id's base minus its own.
   function automatic logic [A_WIDTH-1:0] seg_base(input logic [ID_WIDTH-1:0] id);
      logic [A_WIDTH-1:0] b;
      case (id)
         ID_WIDTH'(4):  b = A_WIDTH'(0);
         ID_WIDTH'(5):  b = A_WIDTH'(952);
         ID_WIDTH'(6):  b = A_WIDTH'(1240);
         ID_WIDTH'(7):  b = A_WIDTH'(1912);
         ID_WIDTH'(8):  b = A_WIDTH'(2968);
         ID_WIDTH'(9):  b = A_WIDTH'(3160);
         ID_WIDTH'(10): b = A_WIDTH'(3608);
         ID_WIDTH'(11): b = A_WIDTH'(4312);
         ID_WIDTH'(12): b = A_WIDTH'(4744);
         ID_WIDTH'(13): b = A_WIDTH'(5716);
         ID_WIDTH'(14): b = A_WIDTH'(7012);
         ID_WIDTH'(15): b = A_WIDTH'(7908);
         ID_WIDTH'(16): b = A_WIDTH'(9924);
         ID_WIDTH'(17): b = A_WIDTH'(12612);
         ID_WIDTH'(18): b = A_WIDTH'(14484);
         ID_WIDTH'(19): b = A_WIDTH'(18516);
         ID_WIDTH'(20): b = A_WIDTH'(24132);
         ID_WIDTH'(21): b = A_WIDTH'(24228);
         ID_WIDTH'(22): b = A_WIDTH'(24964);
         ID_WIDTH'(23): b = A_WIDTH'(28084);
         ID_WIDTH'(24): b = A_WIDTH'(32628);
         ID_WIDTH'(25): b = A_WIDTH'(36416);
         ID_WIDTH'(26): b = A_WIDTH'(41192);
         ID_WIDTH'(27): b = A_WIDTH'(46648);
         ID_WIDTH'(28): b = A_WIDTH'(52680);
         ID_WIDTH'(29): b = A_WIDTH'(57960);
         default:       b = A_WIDTH'(63512);
      endcase
      return b;
   endfunction

   state_t               state;
   logic [A_WIDTH-1:0]   base_r;
   logic [A_WIDTH-1:0]   start_base;
   logic [A_WIDTH-1:0]   end_base;
   logic [ID_WIDTH-1:0]  next_id;
   logic [D_WIDTH-1:0]   start_len;
   logic [D_WIDTH-1:0]   issue_cnt;
   logic [D_WIDTH-1:0]   accept_cnt;
   logic [D_WIDTH-1:0]   inflight_idx;
   logic                 inflight;
   logic                 supported;
   logic                 pop;
   logic                 issue;
   logic [2:0]           credit;
   logic [1:0]           count;
   logic                 wr_ptr;
   logic                 rd_ptr;
   logic [2*D_WIDTH-1:0] fifo_mem [2];

   assign next_id    = link_id + ID_WIDTH'(1);
   assign start_base = seg_base(link_id);
   assign end_base   = seg_base(next_id);
   assign start_len  = D_WIDTH'(end_base - start_base);
   assign supported  = (link_id >= ID_WIDTH'(4)) && (link_id <= ID_WIDTH'(29));

   assign out_valid = (count != 2'd0);
   assign out_idx   = fifo_mem[rd_ptr][2*D_WIDTH-1:D_WIDTH];
   assign out_pi    = fifo_mem[rd_ptr][D_WIDTH-1:0];
   assign pop       = out_valid & out_ready;

   // An issued read lands in the FIFO one cycle later, so it must already hold a slot.
   assign credit = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
   assign issue  = (state == RUN) && (issue_cnt != pi_len) && (credit < 3'd2);

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state        <= IDLE;
         busy         <= 1'b0;
         err          <= 1'b0;
         done         <= 1'b0;
         rom_addr     <= '0;
         pi_len       <= '0;
         base_r       <= '0;
         issue_cnt    <= '0;
         accept_cnt   <= '0;
         inflight     <= 1'b0;
         inflight_idx <= '0;
         count        <= 2'd0;
         wr_ptr       <= 1'b0;
         rd_ptr       <= 1'b0;
         fifo_mem[0]  <= '0;
         fifo_mem[1]  <= '0;
      end else begin
         err  <= 1'b0;
         done <= 1'b0;

         if (inflight) begin
            fifo_mem[wr_ptr] <= {inflight_idx, rom_data};
            wr_ptr           <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr     <= ~rd_ptr;
            accept_cnt <= accept_cnt + D_WIDTH'(1);
         end
         count <= count + {1'b0, inflight} - {1'b0, pop};

         inflight <= issue;
         if (issue) begin
            inflight_idx <= issue_cnt;
            rom_addr     <= base_r + A_WIDTH'(issue_cnt);
            issue_cnt    <= issue_cnt + D_WIDTH'(1);
         end

         case (state)
            IDLE: begin
               if (start) begin
                  if (supported) begin
                     state      <= RUN;
                     busy       <= 1'b1;
                     pi_len     <= start_len;
                     base_r     <= start_base;
                     issue_cnt  <= '0;
                     accept_cnt <= '0;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (issue_cnt == pi_len) state <= DRAIN;
            end
            DRAIN: ;
            default: state <= IDLE;
         endcase

         // Completion is keyed to the final handshake so done lands exactly one cycle later.
         if (state != IDLE && pop && accept_cnt == pi_len - D_WIDTH'(1)) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
         end
      end
   end

endmodule

// File: tb/tb_ter_pi_addr_seq.sv
// Self-checking bench for ter_pi_addr_seq: a stream-level model of the expected
// (i, pi(i)) sequence, address walk, busy/done/err pulses, with directed and random runs.
module tb_ter_pi_addr_seq;

   logic        clk = 1'b0;
   logic        n_rst;
   logic        start;
   logic [5:0]  link_id;
   logic        busy;
   logic        err;
   logic [15:0] rom_addr;
   logic [12:0] rom_data;
   logic [12:0] pi_len;
   logic        out_valid;
   logic        out_ready;
   logic [12:0] out_idx;
   logic [12:0] out_pi;
   logic        done;

   always #5 clk = ~clk;

   ter_pi_addr_seq dut (
      .clk       (clk),
      .n_rst     (n_rst),
      .start     (start),
      .link_id   (link_id),
      .busy      (busy),
      .err       (err),
      .rom_addr  (rom_addr),
      .rom_data  (rom_data),
      .pi_len    (pi_len),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_idx   (out_idx),
      .out_pi    (out_pi),
      .done      (done)
   );

   function automatic logic [12:0] romFunc(input logic [15:0] a);
      int v;
      v = (int'(a) * 40503) ^ (int'(a) >> 3) ^ 1234;
      return v[12:0];
   endfunction

   assign rom_data = romFunc(rom_addr);

   int checkCount = 0;
   int errorCount = 0;

   // Segment bases for ids 4..29 followed by the table end.
   int baseTable [27] = '{0, 952, 1240, 1912, 2968, 3160, 3608, 4312, 4744, 5716,
                          7012, 7908, 9924, 12612, 14484, 18516, 24132, 24228, 24964,
                          28084, 32628, 36416, 41192, 46648, 52680, 57960, 63512};

   bit   busyExp, doneExp, errExp;
   int   segBase, segLen, acceptCnt, addrCnt;
   int   lastAddr, firstAddr;
   int   cycleNo = 0, startCycle = 0, firstValidCycle = -1, doneCycle = 0;
   int   doneCount = 0, errPulses = 0;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checkCount++;
      if (actual != expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0d expected %0d at cycle %0d", name, actual, expected, cycleNo);
      end
   endtask

   // Per-cycle compare against the stream model, then advance the model using this cycle's inputs.
   always @(negedge clk) begin
      if (!n_rst) begin
         busyExp = 0; doneExp = 0; errExp = 0;
         acceptCnt = 0; addrCnt = 0; lastAddr = 0;
      end else begin
         cycleNo++;
         checkOutput("busy", int'(busy), int'(busyExp));
         checkOutput("done", int'(done), int'(doneExp));
         checkOutput("err", int'(err), int'(errExp));
         checkOutput("valid_when_idle", int'(out_valid & ~busyExp), 0);
         if (out_valid) begin
            checkOutput("out_idx", int'(out_idx), acceptCnt);
            checkOutput("out_pi", int'(out_pi), int'(romFunc(16'(segBase + acceptCnt))));
            if (firstValidCycle < 0) firstValidCycle = cycleNo;
         end
         if (busyExp) checkOutput("pi_len", int'(pi_len), segLen);
         if (int'(rom_addr) != lastAddr) begin
            checkOutput("rom_addr", int'(rom_addr), segBase + addrCnt);
            checkOutput("addr_move_when_idle", int'(busyExp), 1);
            if (addrCnt == 0) firstAddr = int'(rom_addr);
            addrCnt++;
            lastAddr = int'(rom_addr);
         end
         checkOutput("outstanding_le2", int'((addrCnt - acceptCnt) <= 2), 1);
         if (done) begin doneCount++; doneCycle = cycleNo; end
         if (err) errPulses++;

         doneExp = 0;
         errExp  = 0;
         if (out_valid && out_ready && busyExp) begin
            acceptCnt++;
            if (acceptCnt == segLen) begin
               doneExp = 1;
               busyExp = 0;
            end
         end else if (start && !busyExp) begin
            if (int'(link_id) >= 4 && int'(link_id) <= 29) begin
               busyExp         = 1;
               segBase         = baseTable[int'(link_id) - 4];
               segLen          = baseTable[int'(link_id) - 3] - segBase;
               acceptCnt       = 0;
               addrCnt         = 0;
               startCycle      = cycleNo;
               firstValidCycle = -1;
            end else begin
               errExp = 1;
            end
         end
      end
   end

   function automatic logic readyFor(input int mode, input int cyc);
      logic [3:0] pattern;
      pattern = 4'b1001;
      case (mode)
         0:       return 1'b1;
         1:       return pattern[3 - (cyc % 4)];
         default: return ($urandom_range(0, 3) != 0);
      endcase
   endfunction

   task automatic checkResetState();
      checkOutput("rst_busy", int'(busy), 0);
      checkOutput("rst_err", int'(err), 0);
      checkOutput("rst_done", int'(done), 0);
      checkOutput("rst_valid", int'(out_valid), 0);
      checkOutput("rst_rom_addr", int'(rom_addr), 0);
      checkOutput("rst_pi_len", int'(pi_len), 0);
      checkOutput("rst_out_idx", int'(out_idx), 0);
      checkOutput("rst_out_pi", int'(out_pi), 0);
   endtask

   // One start pulse, then run the ready pattern until done (or budget/reset point).
   task automatic applyStimulus(input int id, input int mode, input int budget, input bit expectDone,
                                input int interruptBeat, input int interruptId, input int resetBeat);
      int cyc;
      int doneBefore;
      bit sentSecond;
      doneBefore = doneCount;
      sentSecond = 0;
      @(posedge clk); #1;
      start     = 1'b1;
      link_id   = 6'(id);
      out_ready = readyFor(mode, 0);
      cyc = 1;
      @(posedge clk); #1;
      start = 1'b0;
      while ((!expectDone || doneCount == doneBefore) && cyc < budget) begin
         out_ready = readyFor(mode, cyc);
         start     = 1'b0;
         if (interruptBeat >= 0 && acceptCnt == interruptBeat && !sentSecond) begin
            start      = 1'b1;
            link_id    = 6'(interruptId);
            sentSecond = 1;
         end
         if (resetBeat >= 0 && acceptCnt >= resetBeat) begin
            #2 n_rst = 1'b0;
            #1 checkResetState();
            @(posedge clk);
            @(posedge clk); #1;
            n_rst = 1'b1;
            return;
         end
         @(posedge clk); #1;
         cyc++;
      end
      start = 1'b0;
      if (expectDone) checkOutput("done_seen", doneCount - doneBefore, 1);
   endtask

   initial begin
      int doneBefore;
      int errBefore;
      int id;
      n_rst     = 1'b1;
      start     = 1'b0;
      link_id   = '0;
      out_ready = 1'b1;
      #2 n_rst = 1'b0;
      @(posedge clk); #1;
      checkResetState();
      @(posedge clk); #1;
      n_rst = 1'b1;

      $display("[TB] link 5, ready held high");
      applyStimulus(5, 0, 400, 1, -1, 0, -1);
      checkOutput("l5_first_valid_latency", firstValidCycle - startCycle, 3);
      checkOutput("l5_done_cycle", doneCycle - startCycle, 291);
      checkOutput("l5_beats", acceptCnt, 288);
      checkOutput("l5_pi_len", int'(pi_len), 288);
      checkOutput("l5_first_addr", firstAddr, 952);
      checkOutput("l5_last_addr", lastAddr, 1239);
      checkOutput("l5_done_count", doneCount, 1);

      $display("[TB] link 4, ready pattern 1,0,0,1");
      applyStimulus(4, 1, 3000, 1, -1, 0, -1);
      checkOutput("l4_beats", acceptCnt, 952);
      checkOutput("l4_addrs", addrCnt, 952);
      checkOutput("l4_pi_len", int'(pi_len), 952);

      $display("[TB] link 29, ready held high");
      applyStimulus(29, 0, 6000, 1, -1, 0, -1);
      checkOutput("l29_first_addr", firstAddr, 57960);
      checkOutput("l29_last_addr", lastAddr, 63511);
      checkOutput("l29_beats", acceptCnt, 5552);

      $display("[TB] unsupported ids 30 and 2");
      errBefore = errPulses;
      applyStimulus(30, 0, 6, 0, -1, 0, -1);
      applyStimulus(2, 0, 6, 0, -1, 0, -1);
      checkOutput("err_pulses", errPulses - errBefore, 2);
      checkOutput("rom_addr_hold", int'(rom_addr), 63511);

      $display("[TB] link 20 with ignored second start");
      errBefore = errPulses;
      applyStimulus(20, 2, 1000, 1, 10, 7, -1);
      checkOutput("l20_beats", acceptCnt, 96);
      checkOutput("l20_first_addr", firstAddr, 24132);
      checkOutput("l20_no_err", errPulses - errBefore, 0);

      $display("[TB] reset mid-stream of link 13, then link 8");
      doneBefore = doneCount;
      applyStimulus(13, 0, 1000, 0, -1, 0, 100);
      checkOutput("no_done_on_abort", doneCount - doneBefore, 0);
      applyStimulus(8, 2, 1500, 1, -1, 0, -1);
      checkOutput("l8_first_addr", firstAddr, 2968);
      checkOutput("l8_beats", acceptCnt, 192);

      $display("[TB] random runs");
      for (int r = 0; r < 6; r++) begin
         id = $urandom_range(0, 63);
         if (id >= 18 && id < 30) id = id - 12;
         if (id >= 4 && id <= 29) begin
            applyStimulus(id, 2, 6000, 1, -1, 0, -1);
            checkOutput("rand_beats", acceptCnt, baseTable[id - 3] - baseTable[id - 4]);
         end else begin
            errBefore = errPulses;
            applyStimulus(id, 2, 6, 0, -1, 0, -1);
            checkOutput("rand_err", errPulses - errBefore, 1);
         end
      end

      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule

// File: doc/ter_pi_addr_seq.md
Name: ter_pi_addr_seq

Overview:
Sequencer directly upstream of the turbo permutation ROM: owns its 16-bit address bus and consumes its 13-bit data.
- On start, walks the ROM segment of the selected link id (base .. base+len-1).
- Pairs each returned permutation value pi(i) with its index i.
- Streams (i, pi(i)) to the interleaver buffer over a valid/ready handshake, absorbing the fixed 1-cycle ROM read latency.

Parameters:
A_WIDTH, 16, ROM address width
D_WIDTH, 13, ROM data / permutation index width
ID_WIDTH, 6, link id width

Ports:
clk  in  1  system clock, rising edge
n_rst  in  1  asynchronous active-low reset
start  in  1  single-cycle request; sampled only in IDLE
link_id  in  ID_WIDTH  link id, sampled with start
busy  out  1  high from accepted start until done
err  out  1  1-cycle pulse: start with unsupported link_id
rom_addr  out  A_WIDTH  registered address to ROM
rom_data  in  D_WIDTH  ROM output = rom[rom_addr of previous cycle]
pi_len  out  D_WIDTH  segment length of active link (held after done)
out_valid  out  1  output beat valid
out_ready  in  1  downstream accept
out_idx  out  D_WIDTH  sequential index i
out_pi  out  D_WIDTH  pi(i)
done  out  1  1-cycle pulse after last beat accepted

Behaviour:
- Reset (async, n_rst low): state IDLE; busy, err, done, out_valid = 0; rom_addr, pi_len, out_idx, out_pi = 0; FIFO and counters cleared. Reset mid-stream aborts immediately; no done pulse.
- Segment table (base; len = next base - base), hard-coded combinational:
  - Link ids 4..29, bases: 0, 952, 1240, 1912, 2968, 3160, 3608, 4312, 4744, 5716, 7012, 7908, 9924, 12612, 14484, 18516, 24132, 24228, 24964, 28084, 32628, 36416, 41192, 46648, 52680, 57960.
  - End of table = 63512.
- Supported ids 4..29. Ids 0..3 and >=30 (link 30+ segments exceed 2^16) are unsupported: err pulses the cycle after start, state stays IDLE, rom_addr unchanged, busy stays 0.
- States:
  - IDLE: start with supported id -> RUN next cycle. busy=1, pi_len=len, issue counter=0, accept counter=0.
  - RUN: issues addresses under the credit rule. When the issue counter reaches len -> DRAIN.
  - DRAIN: waits until accept counter = len. Then done=1 for one cycle, busy=0 in that same cycle, -> IDLE.
  - start outside IDLE is ignored; no err.
- Issue: rom_addr <= base + issue_cnt (16-bit, never wraps for supported ids); issue_cnt++. Mark an in-flight bit, carrying its index.
- Capture: the cycle after an issue, rom_data and the index are pushed into a 2-entry output FIFO. The FIFO head drives out_valid, out_idx, out_pi.
- Credit rule: issue only if occupancy + inflight - pop < 2, where pop = out_valid & out_ready this cycle. This guarantees no overflow and no lost ROM data.
- Throughput: with out_ready held high, one beat per cycle.
  - Latency start -> first out_valid: 3 cycles (state entry, issue, capture).
  - A len-N link completes in N+3 cycles after start; done pulses the cycle after the last handshake.
- Backpressure: head beat and its values stay stable while out_valid & !out_ready. No duplication or skipping. Order is strictly i = 0..len-1.
- rom_addr holds its last value when not issuing.

Test Plan:
- Reset, start with link_id=5, out_ready=1:
  - rom_addr runs 952..1239; out_idx 0..287 with out_pi = rom[952+i]; exactly 288 beats.
  - done pulses once at cycle 291 after start; pi_len=288.
- link_id=4 with out_ready toggling 1,0,0,1 repeating: all 952 beats arrive in order, none duplicated; FIFO never exceeds 2; out_pi matches the ROM model.
- link_id=29: first rom_addr 57960, last 63511; 5552 beats; done asserted.
- link_id=30, then link_id=2: err pulses once each; busy stays 0; no rom_addr change; no out_valid.
- start(link 20, len 96), then start(link 7) at beat 10: the second start is ignored; stream ends with exactly 96 beats.
- n_rst low at beat 100 of link 13: all outputs 0 asynchronously. After release, start link 8: 192 clean beats starting at rom_addr 2968, idx 0.
